// File: rtl/ov7670_init_seq_if.sv
// ov7670_init_seq_if
//   SCCB writer handshake bundle between the init sequencer and the
//   byte-serialising SCCB writer.
//
//   Handshake: the master raises `en` only while `ready` is high and holds it
//   until it observes `busy`; the slave signals the transaction with `busy`
//   and reports the outcome on `ack` (high near the end of `busy`, or up to
//   two cycles after `busy` falls). `addr`/`data` stay stable while the
//   write is outstanding.
//
//   addr  : register address (master -> slave)
//   data  : register data    (master -> slave)
//   en    : write request    (master -> slave)
//   ready : writer idle and inter-write gap expired (slave -> master)
//   busy  : transaction in progress (slave -> master)
//   ack   : acknowledge indication  (slave -> master)
interface ov7670_init_seq_if;
    logic [7:0] addr;
    logic [7:0] data;
    logic       en;
    logic       ready;
    logic       busy;
    logic       ack;

    modport master (output addr, output data, output en,
                    input  ready, input busy, input ack);
    modport slave  (input  addr, input data, input en,
                    output ready, output busy, output ack);
endinterface

// File: rtl/ov7670_init_seq.sv
// ov7670_init_seq
//   Walks a register table of {reg_addr, reg_data} entries and issues one
//   SCCB write per entry, with retries on NACK, inline delay entries and
//   done/error reporting. Starts automatically after reset; `start` restarts
//   it from DONE, ERROR or IDLE.
//
//   clk_800KHz  : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   start       : restart pulse
//   rom_addr    : table index
//   rom_data    : table entry, 16'hFFFF = end, 16'hFFF0 = delay
//   sccb        : SCCB writer handshake (master side)
//   busy        : sequence in progress
//   done        : table written successfully (level)
//   error       : an entry failed (level)
//   err_index   : index of the failing entry
//   write_count : successful writes in the current sequence
//   dbg_state   : current FSM state
module ov7670_init_seq #(
    parameter int ROM_AW       = 8,
    parameter int RESET_WAIT   = 800,
    parameter int DELAY_CYCLES = 8000,
    parameter int MAX_RETRY    = 3,
    parameter int EN_TIMEOUT   = 64
) (
    input  logic                clk_800KHz,
    input  logic                rst_n,
    input  logic                start,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [15:0]         rom_data,
    ov7670_init_seq_if.master   sccb,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ROM_AW-1:0]   err_index,
    output logic [ROM_AW:0]     write_count,
    output logic [3:0]          dbg_state
);
    localparam int CNT_MAX0 = (RESET_WAIT > DELAY_CYCLES) ? RESET_WAIT : DELAY_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > EN_TIMEOUT) ? CNT_MAX0 : EN_TIMEOUT;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int RTY_W    = $clog2(MAX_RETRY + 2);
    localparam int LAST_IDX = (2 ** ROM_AW) - 1;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_RESET_WAIT = 4'd1;
    localparam logic [3:0] S_FETCH      = 4'd2;
    localparam logic [3:0] S_ISSUE      = 4'd3;
    localparam logic [3:0] S_WAIT_BUSY  = 4'd4;
    localparam logic [3:0] S_WAIT_DONE  = 4'd5;
    localparam logic [3:0] S_CHECK      = 4'd6;
    localparam logic [3:0] S_DELAY      = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;
    localparam logic [3:0] S_ERROR      = 4'd9;

    logic [3:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ROM_AW-1:0] idx_q, idx_d;
    logic [ROM_AW:0]   wc_q, wc_d;
    logic [ROM_AW-1:0] err_idx_q, err_idx_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              en_q, en_d;
    logic              ack_seen_q, ack_seen_d;

    // Two-flop synchronisers; index 1 is the synchronised value.
    logic [1:0] ready_sync_q, busy_sync_q, ack_sync_q;
    logic       ready_s, busy_s, ack_s;

    assign ready_s = ready_sync_q[1];
    assign busy_s  = busy_sync_q[1];
    assign ack_s   = ack_sync_q[1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wc_d       = wc_q;
        err_idx_d  = err_idx_q;
        retry_d    = retry_q;
        addr_d     = addr_q;
        data_d     = data_q;
        en_d       = en_q;
        ack_seen_d = ack_seen_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d   = S_RESET_WAIT;
                    cnt_d     = CNT_W'(RESET_WAIT);
                    idx_d     = '0;
                    wc_d      = '0;
                    err_idx_d = '0;
                    retry_d   = '0;
                end
            end
            S_RESET_WAIT: begin
                if (cnt_q == '0) state_d = S_FETCH;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_FETCH: begin
                // The last table slot is an implicit end marker.
                if (rom_data == 16'hFFFF || idx_q == ROM_AW'(LAST_IDX)) begin
                    state_d = S_DONE;
                end else if (rom_data == 16'hFFF0) begin
                    state_d = S_DELAY;
                    cnt_d   = CNT_W'(DELAY_CYCLES);
                end else begin
                    addr_d  = rom_data[15:8];
                    data_d  = rom_data[7:0];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ready_s) begin
                    en_d       = 1'b1;
                    ack_seen_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                // cnt_q != 0 keeps en high for at least two cycles even if a
                // stale busy is still in the synchroniser.
                if (busy_s && cnt_q != '0) begin
                    en_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CNT_W'(EN_TIMEOUT - 1)) begin
                    en_d    = 1'b0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                // Every cycle here is either busy or within two cycles after
                // busy fell, so any ack seen counts.
                if (ack_s) ack_seen_d = 1'b1;
                if (busy_s)              cnt_d   = '0;
                else if (cnt_q == 1)     state_d = S_CHECK;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            S_CHECK: begin
                if (ack_seen_q) begin
                    wc_d    = wc_q + 1'b1;
                    idx_d   = idx_q + 1'b1;
                    retry_d = '0;
                    state_d = S_FETCH;
                end else if (retry_q < RTY_W'(MAX_RETRY)) begin
                    retry_d = retry_q + 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    err_idx_d = idx_q;
                    state_d   = S_ERROR;
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_RESET_WAIT;
                cnt_d   = CNT_W'(RESET_WAIT);
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_800KHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RESET_WAIT;
            cnt_q        <= CNT_W'(RESET_WAIT);
            idx_q        <= '0;
            wc_q         <= '0;
            err_idx_q    <= '0;
            retry_q      <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            en_q         <= 1'b0;
            ack_seen_q   <= 1'b0;
            ready_sync_q <= '0;
            busy_sync_q  <= '0;
            ack_sync_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            wc_q         <= wc_d;
            err_idx_q    <= err_idx_d;
            retry_q      <= retry_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            en_q         <= en_d;
            ack_seen_q   <= ack_seen_d;
            ready_sync_q <= {ready_sync_q[0], sccb.ready};
            busy_sync_q  <= {busy_sync_q[0], sccb.busy};
            ack_sync_q   <= {ack_sync_q[0], sccb.ack};
        end
    end

    assign rom_addr    = idx_q;
    assign sccb.addr   = addr_q;
    assign sccb.data   = data_q;
    assign sccb.en     = en_q;
    assign busy        = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign done        = (state_q == S_DONE);
    assign error       = (state_q == S_ERROR);
    assign err_index   = err_idx_q;
    assign write_count = wc_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_ov7670_init_seq.sv
// tb_ov7670_init_seq
//   Bench for ov7670_init_seq: a table ROM, a negedge-sampling SCCB writer
//   model, and a reference model that derives the expected write attempts
//   and final status straight from the table and a per-entry NACK plan.
module tb_ov7670_init_seq;
    localparam int ROM_AW       = 4;
    localparam int DEPTH        = 2 ** ROM_AW;
    localparam int RESET_WAIT   = 800;
    localparam int DELAY_CYCLES = 8000;
    localparam int MAX_RETRY    = 3;
    localparam int EN_TIMEOUT   = 64;
    localparam int BUDGET       = 30000;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              dut_busy, dut_done, dut_error;
    logic [ROM_AW-1:0] err_index;
    logic [ROM_AW:0]   write_count;
    logic [3:0]        dbg_state;
    logic [15:0]       rom_mem [DEPTH];

    assign rom_data = rom_mem[rom_addr];

    ov7670_init_seq_if sccb_if ();

    ov7670_init_seq #(
        .ROM_AW(ROM_AW), .RESET_WAIT(RESET_WAIT), .DELAY_CYCLES(DELAY_CYCLES),
        .MAX_RETRY(MAX_RETRY), .EN_TIMEOUT(EN_TIMEOUT)
    ) dut (
        .clk_800KHz(clk), .rst_n(rst_n), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data), .sccb(sccb_if),
        .busy(dut_busy), .done(dut_done), .error(dut_error),
        .err_index(err_index), .write_count(write_count), .dbg_state(dbg_state)
    );

    // Scoreboard
    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];
    logic        ack_plan_q[$];
    int          acc_cyc[$];
    int          nack_plan [DEPTH];
    bit          dead_mode = 1'b0;
    logic        exp_done, exp_error;
    int          exp_err_idx, exp_wc, exp_attempts;
    int          attempts = 0;
    int          en_rises = 0;
    int          en_len = 0;
    logic        en_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: walk the table by its encoding rules.
    task automatic build_expect();
        int i;
        exp_q.delete();
        ack_plan_q.delete();
        exp_done = 0; exp_error = 0; exp_err_idx = 0; exp_wc = 0; exp_attempts = 0;
        i = 0;
        while (1) begin
            if (i == DEPTH - 1 || rom_mem[i] == 16'hFFFF) begin
                exp_done = 1;
                break;
            end
            if (rom_mem[i] != 16'hFFF0) begin
                if (dead_mode) begin
                    exp_error = 1; exp_err_idx = i;
                    break;
                end
                for (int k = 0; k < nack_plan[i] && k <= MAX_RETRY; k++) begin
                    exp_q.push_back(rom_mem[i]);
                    ack_plan_q.push_back(1'b0);
                    exp_attempts++;
                end
                if (nack_plan[i] > MAX_RETRY) begin
                    exp_error = 1; exp_err_idx = i;
                    break;
                end
                exp_q.push_back(rom_mem[i]);
                ack_plan_q.push_back(1'b1);
                exp_attempts++;
                exp_wc++;
            end
            i++;
        end
    endtask

    // Writer model: samples en on the falling edge like the real writer.
    initial begin
        sccb_if.ready = 1'b1;
        sccb_if.busy  = 1'b0;
        sccb_if.ack   = 1'b0;
    end

    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            if (sccb_if.en && !en_prev) begin
                en_rises++;
                en_len = 1;
                chk("en_rise_needs_ready", 32'(sccb_if.ready), 1);
            end else if (sccb_if.en) begin
                en_len++;
            end else if (en_prev) begin
                chk("en_hold_ge2", 32'(en_len >= 2), 1);
            end
        end
        en_prev = sccb_if.en;
    endtask

    initial begin : writer
        logic [15:0] e;
        logic        ack_v;
        forever begin
            tick();
            if (!dead_mode && sccb_if.ready && sccb_if.en) begin
                attempts++;
                acc_cyc.push_back(cyc);
                chk("write_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("write_addr", 32'(sccb_if.addr), 32'(e[15:8]));
                    chk("write_data", 32'(sccb_if.data), 32'(e[7:0]));
                end
                ack_v = (ack_plan_q.size() > 0) ? ack_plan_q.pop_front() : 1'b1;
                sccb_if.ready = 1'b0;
                sccb_if.busy  = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    tick();
                    sccb_if.ack = (k >= 5) ? ack_v : 1'b0;
                end
                sccb_if.busy = 1'b0;
                tick();
                sccb_if.ack = 1'b0;
                repeat (3) tick();
                sccb_if.ready = 1'b1;
            end
        end
    end

    // Driver tasks
    task automatic clear_plan();
        for (int i = 0; i < DEPTH; i++) nack_plan[i] = 0;
    endtask

    task automatic fill_random(input bit with_end);
        int len;
        len = $urandom_range(1, DEPTH - 1);
        for (int i = 0; i < DEPTH; i++) begin
            rom_mem[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
            case ($urandom_range(0, 9))
                6, 7:    nack_plan[i] = 1;
                8:       nack_plan[i] = 2;
                9:       nack_plan[i] = $urandom_range(3, 5);
                default: nack_plan[i] = 0;
            endcase
        end
        if (with_end) rom_mem[len] = 16'hFFFF;
    endtask

    int start_cyc = 0;

    task automatic start_seq();
        attempts = 0;
        en_rises = 0;
        acc_cyc.delete();
        build_expect();
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("restart_write_count", 32'(write_count), 0);
        chk("restart_err_index", 32'(err_index), 0);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (dut_busy && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("sequence_finished", 32'(!dut_busy), 1);
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_done"}, 32'(dut_done), 32'(exp_done));
        chk({tag, "_error"}, 32'(dut_error), 32'(exp_error));
        chk({tag, "_write_count"}, 32'(write_count), 32'(exp_wc));
        if (exp_error) chk({tag, "_err_index"}, 32'(err_index), 32'(exp_err_idx));
        chk({tag, "_attempts"}, 32'(attempts), 32'(exp_attempts));
        chk({tag, "_exp_q_drained"}, 32'(exp_q.size()), 0);
    endtask

    task automatic check_reset_values();
        chk("rst_sccb_en", 32'(sccb_if.en), 0);
        chk("rst_sccb_addr", 32'(sccb_if.addr), 0);
        chk("rst_sccb_data", 32'(sccb_if.data), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_busy", 32'(dut_busy), 1);
        chk("rst_done", 32'(dut_done), 0);
        chk("rst_error", 32'(dut_error), 0);
        chk("rst_err_index", 32'(err_index), 0);
        chk("rst_write_count", 32'(write_count), 0);
    endtask

    // Main sequence
    initial begin
        int n;
        // Directed table with a delay entry, run from power-up reset.
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = 16'hFFFF;
        rom_mem[0] = 16'h1280; rom_mem[1] = 16'hFFF0; rom_mem[2] = 16'h1101;
        clear_plan();
        build_expect();
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        wait_end();
        check_result("delay_table");
        chk("delay_two_writes", 32'(acc_cyc.size()), 2);
        if (acc_cyc.size() == 2)
            chk("delay_gap_ge", 32'(acc_cyc[1] - acc_cyc[0] >= DELAY_CYCLES), 1);

        // Entry 1 NACKed twice, then ACKed.
        rom_mem[0] = 16'h1280; rom_mem[1] = 16'h1101; rom_mem[2] = 16'h3A04; rom_mem[3] = 16'hFFFF;
        clear_plan();
        nack_plan[1] = 2;
        start_seq();
        wait_end();
        check_result("nack_twice");

        // Entry 2 always NACKed.
        clear_plan();
        nack_plan[2] = 99;
        start_seq();
        wait_end();
        check_result("nack_always");

        // Writer never raises busy.
        clear_plan();
        dead_mode = 1'b1;
        start_seq();
        wait_end();
        check_result("busy_dead");
        chk("busy_dead_en_rises", 32'(en_rises), 32'(MAX_RETRY + 1));
        n = cyc - start_cyc;
        chk("busy_dead_min_time", 32'(n >= RESET_WAIT + (MAX_RETRY + 1) * EN_TIMEOUT), 1);
        chk("busy_dead_max_time", 32'(n <= RESET_WAIT + (MAX_RETRY + 1) * (EN_TIMEOUT + 10) + 20), 1);
        dead_mode = 1'b0;

        // No end marker: last slot acts as the end.
        clear_plan();
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = {8'(i + 8'h20), 8'($urandom_range(0, 255))};
        start_seq();
        wait_end();
        check_result("no_end_marker");
        chk("no_end_rom_addr", 32'(rom_addr), 32'(DEPTH - 1));

        // Reset in the middle of a write, then start after DONE.
        clear_plan();
        fill_random(1'b1);
        for (int i = 0; i < DEPTH; i++) nack_plan[i] = 0;
        rom_mem[0] = 16'h4D40; rom_mem[1] = 16'h5566;
        start_seq();
        n = 0;
        while (!sccb_if.busy && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("midreset_write_seen", 32'(sccb_if.busy), 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values();
        attempts = 0;
        acc_cyc.delete();
        build_expect();
        @(negedge clk);
        rst_n = 1'b1;
        wait_end();
        check_result("after_reset");
        start_seq();
        wait_end();
        check_result("restart");
        if (acc_cyc.size() > 0)
            chk("restart_first_en_latency", 32'(acc_cyc[0] - start_cyc >= RESET_WAIT), 1);

        // Randomised tables and NACK plans.
        for (int r = 0; r < 8; r++) begin
            clear_plan();
            fill_random(r % 3 != 2);
            start_seq();
            wait_end();
            check_result("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
